// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//
// Purpose: circular instruction queue between the instruction memory and a
// dual-issue decoder. It holds up to DEPTH {instr, pc} entries. The two
// oldest entries are exposed combinationally as the even and odd issue
// slots, and the decoder retires 0, 1 or 2 of them per cycle.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-low reset
//   in_valid   upstream presents in_instr/in_pc/in_last
//   in_instr   instruction word
//   in_pc      address tag of in_instr
//   in_last    in_instr is the final instruction of the program
//   in_ready   queue accepts a push this cycle
//   flush      branch redirect, discards every queued entry
//   pop_cnt    entries consumed by the decoder this cycle (3 is illegal)
//   out_valid0/out_instr0/out_pc0   head entry (even slot)
//   out_valid1/out_instr1/out_pc1   head+1 entry (odd slot)
//   count      occupied entries
//   done       final instruction accepted and queue drained
//   err        sticky protocol-error flag (over-pop or pop_cnt = 3)
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
   parameter int DEPTH = 8,
   parameter int PC_W  = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [31:0]                in_instr,
   input  logic [PC_W-1:0]            in_pc,
   input  logic                       in_last,
   output logic                       in_ready,
   input  logic                       flush,
   input  logic [1:0]                 pop_cnt,
   output logic                       out_valid0,
   output logic [31:0]                out_instr0,
   output logic [PC_W-1:0]            out_pc0,
   output logic                       out_valid1,
   output logic [31:0]                out_instr1,
   output logic [PC_W-1:0]            out_pc1,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       done,
   output logic                       err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

   // Storage is never reset: only the pointers and count define what is live.
   logic [31:0]     instr_mem_q [DEPTH];
   logic [PC_W-1:0] pc_mem_q    [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          last_seen_q, last_seen_d;
   logic          err_q, err_d;

   logic          push_s;
   logic [1:0]    pop_req_s;
   logic [1:0]    eff_pop_s;
   logic          pop_err_s;
   logic [AW-1:0] rd_ptr_nxt1_s;

   // Acceptance depends on registered state plus flush only, never on pop_cnt,
   // so a full queue stays closed in a cycle where the decoder pops.
   assign in_ready = (count_q < CNT_DEPTH) && !last_seen_q && !flush;
   assign push_s   = in_valid && in_ready;

   // Odd slot reads head+1; AW-bit arithmetic wraps it past DEPTH-1.
   assign rd_ptr_nxt1_s = rd_ptr_q + PTR_ONE;

   assign out_valid0 = (count_q >= CW'(1));
   assign out_valid1 = (count_q >= CW'(2));
   assign out_instr0 = instr_mem_q[rd_ptr_q];
   assign out_pc0    = pc_mem_q[rd_ptr_q];
   assign out_instr1 = instr_mem_q[rd_ptr_nxt1_s];
   assign out_pc1    = pc_mem_q[rd_ptr_nxt1_s];

   assign count = count_q;
   assign done  = last_seen_q && (count_q == CW'(0));
   assign err   = err_q;

   // Pop clamping: 3 is treated as 2, then limited to what is actually queued.
   always_comb begin
      pop_req_s = pop_cnt;
      eff_pop_s = 2'd0;
      pop_err_s = 1'b0;
      if (pop_cnt == 2'd3) begin
         pop_req_s = 2'd2;
      end else begin
         pop_req_s = pop_cnt;
      end
      if (CW'(pop_req_s) > count_q) begin
         // Only reachable with count_q <= 1, so the low bits hold it exactly.
         eff_pop_s = count_q[1:0];
      end else begin
         eff_pop_s = pop_req_s;
      end
      pop_err_s = (pop_cnt == 2'd3) || (CW'(pop_cnt) > count_q);
   end

   // Next-state for pointers, count and flags; flush overrides push and pop.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      last_seen_d = last_seen_q;
      err_d       = err_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         last_seen_d = 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         rd_ptr_d = rd_ptr_q + AW'(eff_pop_s);
         count_d  = count_q + CW'(push_s) - CW'(eff_pop_s);
         if (push_s && in_last) begin
            last_seen_d = 1'b1;
         end else begin
            last_seen_d = last_seen_q;
         end
         if (pop_err_s) begin
            err_d = 1'b1;
         end else begin
            err_d = err_q;
         end
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         last_seen_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         last_seen_q <= last_seen_d;
         err_q       <= err_d;
      end
   end

   // Entry storage write; a push during reset is dropped.
   always_ff @(posedge clk) begin
      if (rst && push_s) begin
         instr_mem_q[wr_ptr_q] <= in_instr;
         pc_mem_q[wr_ptr_q]    <= in_pc;
      end
   end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (power of two, >= 2).
REQ-002 SHALL have parameter PC_W, default 10, width of the instruction address tag.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 in_valid  input  1  upstream instruction memory presents an instruction.
REQ-006 in_instr  input  32  instruction word.
REQ-007 in_pc  input  PC_W  address of in_instr.
REQ-008 in_last  input  1  marks in_instr as the final instruction of the program.
REQ-009 in_ready  output  1  queue accepts a push this cycle.
REQ-010 flush  input  1  branch redirect; discard all queued entries.
REQ-011 pop_cnt  input  2  entries the decoder consumes this cycle (0, 1 or 2; 3 is illegal).
REQ-012 out_valid0/out_instr0/out_pc0  output  1/32/PC_W  head entry (even issue slot).
REQ-013 out_valid1/out_instr1/out_pc1  output  1/32/PC_W  head+1 entry (odd issue slot).
REQ-014 count  output  log2(DEPTH)+1  occupied entries.
REQ-015 done  output  1  final instruction accepted and queue drained.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 Circular buffer of DEPTH entries {instr, pc}; write pointer, read pointer, registered count.
REQ-018 in_ready = (count < DEPTH) and not last_seen and not flush; from registered state only, no dependency on pop_cnt.
REQ-019 Push occurs when in_valid and in_ready; entry written at write pointer, pointer increments modulo DEPTH.
REQ-020 Outputs combinational from storage: out_valid0 = (count >= 1), out_valid1 = (count >= 2); slot data undefined when its valid is 0.
REQ-021 Effective pop = min(pop_cnt, count); read pointer advances by effective pop modulo DEPTH.
REQ-022 pop_cnt greater than count, or pop_cnt = 3, SHALL set err; pop clamped per REQ-021 (pop_cnt = 3 treated as 2 then clamped).
REQ-023 Simultaneous push and pop: next count = count + push - effective pop; pushed entry never visible on outputs in the cycle it is written (latency 1 cycle, push to out_valid0).
REQ-024 Full queue (count = DEPTH) with pop_cnt > 0: in_ready stays 0 that cycle; space available next cycle.
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order, including a 2-entry pop straddling the wrap.
REQ-026 Accepted push with in_last = 1 SHALL set internal last_seen; further in_valid ignored (in_ready = 0) until flush or reset.
REQ-027 done = last_seen and (count = 0), registered state only.
REQ-028 flush: next count = 0, pointers = 0, last_seen = 0; push and pop in the flush cycle discarded; err unchanged.
REQ-029 flush has priority over push and pop; reset has priority over flush.

Reset
REQ-030 rst = 0 at a rising edge: count = 0, pointers = 0, last_seen = 0, err = 0; thus in_ready = 1, out_valid0 = out_valid1 = 0, done = 0 from next cycle.
REQ-031 Reset mid-operation discards all entries; storage contents need not be cleared.
REQ-032 Ignored during reset: in_valid, pop_cnt, flush.

Verification
REQ-033 Push 0x11111111@pc0, 0x22222222@pc1, pop_cnt = 0 -> count = 2, out0 = 0x11111111/pc0, out1 = 0x22222222/pc1, both valid.
REQ-034 Fill 8 entries, then in_valid with pop_cnt = 2 -> in_ready = 0, count = 6 next cycle, in_ready = 1 next cycle.
REQ-035 Read pointer at 7 with 2 entries, pop_cnt = 2 plus push -> both popped in order across wrap, count = 1, out0 = pushed word.
REQ-036 count = 1, pop_cnt = 2 -> count = 0, err = 1 and stays 1 until reset.
REQ-037 Push with in_last = 1, drain with pop_cnt = 1 -> done = 1 when count = 0; in_ready = 0; flush -> done = 0, in_ready = 1.
REQ-038 count = 5, flush and push and pop_cnt = 2 same cycle -> count = 0 next cycle; rst = 0 mid-stream -> count = 0, err = 0.
